stage_write_mw: RTL
===================

Name: stage_write_mw

Overview:
- Parametrised multi-lane writeback/retire stage; successor to the single-lane writeback stage.
- Sits after memory1. Accepts up to LANES in-order results per cycle and selects the oldest exception.
- Drives per-lane register-file write ports to decode and sequences flush/exception stalls against in-flight cache bus activity in fetch1/memory1.
- Produces retire count and exception/flush reporting for the CSR unit.

Parameters:
- LANES, 2, number of parallel writeback lanes, lane 0 oldest (1..4)
- XLEN, 32, data width of wb_data per lane

Ports:
- clk_core  in  1  core clock
- reset_n  in  1  reset; asynchronous, active-low
- fe1_busy  in  1  fetch1 cache fill/evict in progress
- mem1_busy  in  1  memory1 cache fill/evict in progress
- mem1_stall  in  1  memory1 not presenting results this cycle
- mem1_valid_wb  in  LANES  lane holds a retiring insn
- mem1_exc  in  LANES  lane raised exception
- mem1_exc_cause  in  LANES x ecause_t  per-lane cause
- mem1_flush  in  LANES  lane requires pipeline flush (fence.i/CSR write)
- mem1_pc  in  LANES x 30  pc[31:2] per lane
- mem1_wb_reg  in  LANES x 5  destination register
- mem1_dout  in  LANES x XLEN  result data
- csr_kill  in  1  kill all incoming lanes
- wb_stall  out  1  hold memory1
- wb_valid  out  LANES  lane retires this cycle
- wb_we  out  LANES  register write enable to decode
- wb_reg  out  LANES x 5  write register
- wb_data  out  LANES x XLEN  write data
- wb_exc  out  1  exception pending
- wb_exc_cause  out  ecause_t  cause of oldest excepting lane
- wb_flush  out  1  flush pending
- wb_pc  out  30  pc of excepting/flushing lane, else of lane 0
- wb_retire_cnt  out  $clog2(LANES+1)  popcount of wb_valid

Behaviour:
- Reset (async, reset_n low): wb_valid=0, wb_we=0, wb_exc=0, wb_flush=0, wb_retire_cnt=0, FSM=RUN. Data, reg, cause and pc are don't-care.
- Capture on posedge clk_core when ~wb_stall; 1-cycle latency.
- Capture gating:
  - k = lowest lane with mem1_valid_wb|mem1_exc and mem1_exc set.
  - f = lowest valid lane with mem1_flush.
  - Lane i valid iff mem1_valid_wb[i] & ~mem1_stall & ~csr_kill & ~mem1_exc[i], and i<k, and i<=f. Younger lanes are dropped.
- Exception capture: wb_exc = (k exists) & ~mem1_stall & ~csr_kill; wb_exc_cause and wb_pc taken from lane k.
- Flush capture: wb_flush = (f exists) & (f<k). If an exception and a flush are both present, the older one wins.
- Write enable: wb_we[i] = wb_valid[i] & (wb_reg[i]!=0).
  - WAW within a group: if lanes i<j write the same register, wb_we[i]=0.
- FSM states: RUN, FLUSH_HOLD, DRAIN.
  - RUN: wb_stall = wb_exc & (fe1_busy|mem1_busy). A capture with wb_flush=1 goes to FLUSH_HOLD.
  - FLUSH_HOLD: wb_stall=1 unconditionally; go to DRAIN next cycle. Guarantees at least one flush stall cycle.
  - DRAIN: wb_stall = fe1_busy|mem1_busy. When both are low, stall drops, the next group is captured, and the FSM goes to RUN (or back to FLUSH_HOLD if the new group flushes).
- While stalled, all outputs hold. wb_valid lanes are not re-counted: retire is reported only on cycles where ~wb_stall.
- Reset asserted mid-flush/drain returns the FSM to RUN immediately; a pending flush is discarded.
- LANES=1 must reproduce single-lane writeback timing exactly.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: adds output wb_instret (64 bits) and input csr_instret_wr (1) with csr_instret_wdata (64).
  - On ~wb_stall, wb_instret += wb_retire_cnt.
  - csr_instret_wr overrides the increment on the same cycle.
  - Resets to 0.
- Undefined: ports and counter absent.

Decomposition:
- Add to the shared defines package:
  - wb_state_t enum {RUN, FLUSH_HOLD, DRAIN}
  - the existing ecause_t, TEST_MAGIC
- One sub-module, wb_lane_select: combinational priority encoder over LANES producing k, f, the lane-valid mask and the WAW mask. The FSM and registers stay in stage_write_mw.

Test Plan:
- LANES=2, both valid, regs x5/x6, data 0x11/0x22 -> next cycle wb_we=2'b11, wb_retire_cnt=2.
- Lane0 writes x0, lane1 writes x7 -> wb_we=2'b10.
- Both lanes write x9 (0xA, 0xB) -> wb_we=2'b10, x9 gets 0xB.
- Lane1 exc IILLEGAL at pc 0x104, fe1_busy high 3 cycles -> wb_valid=2'b01, wb_exc=1, wb_pc=0x104>>2, wb_stall high exactly 3 cycles.
- Lane0 flush, lane1 valid, mem1_busy=0 -> lane1 dropped, wb_stall high exactly 1 cycle, then FSM=RUN.
- reset_n pulsed low during DRAIN with mem1_busy=1 -> wb_stall=0, wb_flush=0 immediately; counter (if WB_INSTRET_EN) = 0.

Source files
------------

// File: rtl/stage_write_mw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_write_mw_pkg
// Description : Shared defines for the writeback/retire stage: exception
//               cause encoding, writeback FSM state encoding, test magic
//               word and a small index-width helper.
// Revision    : 1.0 - multi-lane writeback
// ============================================================================
package stage_write_mw_pkg;

    localparam int ECAUSE_W = 4;

    // Exception causes, numbered as the RISC-V mcause exception codes.
    typedef enum logic [ECAUSE_W-1:0] {
        IMISALIGN = 4'd0,
        IFAULT    = 4'd1,
        IILLEGAL  = 4'd2,
        BREAKPT   = 4'd3,
        LMISALIGN = 4'd4,
        LFAULT    = 4'd5,
        SMISALIGN = 4'd6,
        SFAULT    = 4'd7,
        ECALL_U   = 4'd8,
        ECALL_M   = 4'd11
    } ecause_t;

    localparam logic [31:0] TEST_MAGIC = 32'h4D57_0001;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_HOLD = 2'd1,
        DRAIN      = 2'd2
    } wb_state_t;

    // Width of a lane index; a single-lane build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_write_mw_lane_select.sv
`default_nettype none
// ============================================================================
// Module      : wb_lane_select
// Description : Combinational priority encoder over the writeback lanes.
//               Finds the oldest excepting lane (k) and the oldest valid
//               flushing lane (f), builds the retiring-lane mask and the
//               write-after-write suppression mask.
// Ports       : i_valid_wb/i_exc/i_flush  per-lane status from memory1
//               i_wb_reg                  per-lane destination register
//               i_live                    group is presented and not killed
//               o_k_found/o_k_idx         oldest excepting lane
//               o_f_found/o_f_idx         oldest valid flushing lane
//               o_lane_valid              lanes that retire
//               o_waw_mask                lanes overwritten by a younger lane
// Revision    : 1.0 - multi-lane writeback
// ============================================================================
module wb_lane_select
    import stage_write_mw_pkg::*;
#(
    parameter  int LANES = 2,
    localparam int IDX_W = idx_width(LANES)
) (
    input  logic [LANES-1:0]      i_valid_wb,
    input  logic [LANES-1:0]      i_exc,
    input  logic [LANES-1:0]      i_flush,
    input  logic [LANES-1:0][4:0] i_wb_reg,
    input  logic                  i_live,
    output logic                  o_k_found,
    output logic [IDX_W-1:0]      o_k_idx,
    output logic                  o_f_found,
    output logic [IDX_W-1:0]      o_f_idx,
    output logic [LANES-1:0]      o_lane_valid,
    output logic [LANES-1:0]      o_waw_mask
);

    // Scan youngest to oldest so the last hit is the oldest lane.
    always_comb begin
        o_k_found = 1'b0;
        o_k_idx   = '0;
        o_f_found = 1'b0;
        o_f_idx   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_exc[i]) begin
                o_k_found = 1'b1;
                o_k_idx   = IDX_W'(i);
            end
            if (i_valid_wb[i] && i_flush[i]) begin
                o_f_found = 1'b1;
                o_f_idx   = IDX_W'(i);
            end
        end
    end

    // A lane retires only if older than the exception and not younger
    // than the flush; the flushing lane itself still retires.
    always_comb begin
        o_lane_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            o_lane_valid[i] = i_valid_wb[i] & i_live & ~i_exc[i]
                            & (~o_k_found | (IDX_W'(i) <  o_k_idx))
                            & (~o_f_found | (IDX_W'(i) <= o_f_idx));
        end
    end

    // Only the youngest retiring writer of a register keeps its write.
    always_comb begin
        o_waw_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (o_lane_valid[j] && (i_wb_reg[j] == i_wb_reg[i])) begin
                    o_waw_mask[i] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_write_mw.sv
`default_nettype none
// ============================================================================
// Module      : stage_write_mw
// Description : Multi-lane writeback/retire stage. Captures up to LANES
//               in-order results from memory1, drives register-file write
//               ports, reports the oldest exception or flush and sequences
//               flush/exception stalls against fetch1/memory1 cache activity.
// Ports       : clk_core/reset_n      clock, async active-low reset
//               fe1_busy/mem1_busy    cache fill/evict in progress
//               mem1_*                per-lane results from memory1
//               csr_kill              kill all incoming lanes
//               wb_stall              hold memory1
//               wb_valid/wb_we        retiring lanes / register write enables
//               wb_reg/wb_data        write register / data per lane
//               wb_exc/wb_exc_cause   oldest exception and its cause
//               wb_flush              flush pending
//               wb_pc                 pc of excepting/flushing lane, else lane 0
//               wb_retire_cnt         popcount of wb_valid
// Options     : WB_INSTRET_EN adds a 64-bit retired-instruction counter
//               (wb_instret) with CSR write port csr_instret_wr/_wdata.
// Revision    : 1.0 - multi-lane writeback
// ============================================================================
module stage_write_mw
    import stage_write_mw_pkg::*;
#(
    parameter  int LANES = 2,
    parameter  int XLEN  = 32,
    localparam int IDX_W = idx_width(LANES),
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic                             clk_core,
    input  logic                             reset_n,
    input  logic                             fe1_busy,
    input  logic                             mem1_busy,
    input  logic                             mem1_stall,
    input  logic [LANES-1:0]                 mem1_valid_wb,
    input  logic [LANES-1:0]                 mem1_exc,
    input  logic [LANES-1:0][ECAUSE_W-1:0]   mem1_exc_cause,
    input  logic [LANES-1:0]                 mem1_flush,
    input  logic [LANES-1:0][29:0]           mem1_pc,
    input  logic [LANES-1:0][4:0]            mem1_wb_reg,
    input  logic [LANES-1:0][XLEN-1:0]       mem1_dout,
    input  logic                             csr_kill,
`ifdef WB_INSTRET_EN
    input  logic                             csr_instret_wr,
    input  logic [63:0]                      csr_instret_wdata,
    output logic [63:0]                      wb_instret,
`endif
    output logic                             wb_stall,
    output logic [LANES-1:0]                 wb_valid,
    output logic [LANES-1:0]                 wb_we,
    output logic [LANES-1:0][4:0]            wb_reg,
    output logic [LANES-1:0][XLEN-1:0]       wb_data,
    output logic                             wb_exc,
    output ecause_t                          wb_exc_cause,
    output logic                             wb_flush,
    output logic [29:0]                      wb_pc,
    output logic [CNT_W-1:0]                 wb_retire_cnt
);

    logic                 w_live;
    logic                 w_k_found;
    logic [IDX_W-1:0]     w_k_idx;
    logic                 w_f_found;
    logic [IDX_W-1:0]     w_f_idx;
    logic [LANES-1:0]     w_lane_valid;
    logic [LANES-1:0]     w_waw_mask;
    logic [LANES-1:0]     w_we;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_flush_older;
    logic                 w_exc;
    logic                 w_flush;
    logic [29:0]          w_pc;

    wb_state_t                   state_q, state_d;
    logic [LANES-1:0]            valid_q, valid_d;
    logic [LANES-1:0]            we_q, we_d;
    logic [LANES-1:0][4:0]       reg_q, reg_d;
    logic [LANES-1:0][XLEN-1:0]  data_q, data_d;
    logic                        exc_q, exc_d;
    ecause_t                     cause_q, cause_d;
    logic                        flush_q, flush_d;
    logic [29:0]                 pc_q, pc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    assign w_live = ~mem1_stall & ~csr_kill;

    wb_lane_select #(
        .LANES (LANES)
    ) u_lane_select (
        .i_valid_wb   (mem1_valid_wb),
        .i_exc        (mem1_exc),
        .i_flush      (mem1_flush),
        .i_wb_reg     (mem1_wb_reg),
        .i_live       (w_live),
        .o_k_found    (w_k_found),
        .o_k_idx      (w_k_idx),
        .o_f_found    (w_f_found),
        .o_f_idx      (w_f_idx),
        .o_lane_valid (w_lane_valid),
        .o_waw_mask   (w_waw_mask)
    );

    // A flush older than any exception wins and masks the exception; a
    // stalled or killed group has nothing to report.
    assign w_flush_older = w_f_found & (~w_k_found | (w_f_idx < w_k_idx));
    assign w_flush       = w_flush_older & w_live;
    assign w_exc         = w_k_found & w_live & ~w_flush_older;
    assign w_pc          = w_exc   ? mem1_pc[w_k_idx] :
                           w_flush ? mem1_pc[w_f_idx] : mem1_pc[0];

    always_comb begin
        w_we  = '0;
        w_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_we[i] = w_lane_valid[i] & ~w_waw_mask[i] & (mem1_wb_reg[i] != 5'd0);
            w_cnt   = w_cnt + CNT_W'(w_lane_valid[i]);
        end
    end

    // Stall/next-state; every output register holds while stalled.
    always_comb begin
        state_d  = state_q;
        wb_stall = 1'b0;
        valid_d  = valid_q;
        we_d     = we_q;
        reg_d    = reg_q;
        data_d   = data_q;
        exc_d    = exc_q;
        cause_d  = cause_q;
        flush_d  = flush_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;

        case (state_q)
            RUN: begin
                wb_stall = exc_q & (fe1_busy | mem1_busy);
                if (!wb_stall && w_flush) begin
                    state_d = FLUSH_HOLD;
                end
            end
            FLUSH_HOLD: begin
                wb_stall = 1'b1;
                state_d  = DRAIN;
            end
            DRAIN: begin
                wb_stall = fe1_busy | mem1_busy;
                if (!wb_stall) begin
                    state_d = w_flush ? FLUSH_HOLD : RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!wb_stall) begin
            valid_d = w_lane_valid;
            we_d    = w_we;
            reg_d   = mem1_wb_reg;
            data_d  = mem1_dout;
            exc_d   = w_exc;
            cause_d = ecause_t'(mem1_exc_cause[w_k_idx]);
            flush_d = w_flush;
            pc_d    = w_pc;
            cnt_d   = w_cnt;
        end
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            valid_q <= '0;
            we_q    <= '0;
            exc_q   <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            exc_q   <= exc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload registers are qualified by the valid/exc/flush flags.
    always_ff @(posedge clk_core) begin
        reg_q   <= reg_d;
        data_q  <= data_d;
        cause_q <= cause_d;
        pc_q    <= pc_d;
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // A group is counted once, on the cycle its stall finally drops.
    always_comb begin
        instret_d = instret_q;
        if (csr_instret_wr) begin
            instret_d = csr_instret_wdata;
        end else if (!wb_stall) begin
            instret_d = instret_q + 64'(cnt_q);
        end
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign wb_instret = instret_q;
`endif

    assign wb_valid      = valid_q;
    assign wb_we         = we_q;
    assign wb_reg        = reg_q;
    assign wb_data       = data_q;
    assign wb_exc        = exc_q;
    assign wb_exc_cause  = cause_q;
    assign wb_flush      = flush_q;
    assign wb_pc         = pc_q;
    assign wb_retire_cnt = cnt_q;

endmodule
`default_nettype wire
